// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: request side (i_*) and result side (o_*).
// master drives operands and result-ready; slave is the ALU.
interface alu_seq_if #(
  parameter int BITS = 8
);
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_b;
  logic [2:0]      i_op;
  logic            o_valid;
  logic            i_ready;
  logic [BITS-1:0] o_out;
  logic            o_ovf;
  logic            o_ERR;
  logic            o_even;
  logic            o_single;

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_ready,
    output o_ready, o_valid, o_out, o_ovf, o_ERR, o_even, o_single
  );

  modport master (
    output i_valid, i_a, i_b, i_op, i_ready,
    input  o_ready, o_valid, o_out, o_ovf, o_ERR, o_even, o_single
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU (SUB/CMP/SHL/CHG/SHR), one op per handshake; shifts run one bit per cycle.
// Latency: result registered at accept, or b cycles later for shifts by b>=1. ALU_STICKY_ERR_EN adds a sticky error flag.
// Backpressure: o_ready only in IDLE; the result is held in DONE until i_ready.
module alu_seq #(
  parameter int BITS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_seq_if.slave   bus
`ifdef ALU_STICKY_ERR_EN
  ,
  input  logic       i_err_clr,
  output logic       o_err_sticky
`endif
);
  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] work_q, work_d;
  logic [BITS-1:0] out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            sh_ovf_q, sh_ovf_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            even_q, even_d;
  logic            single_q, single_d;
  logic            b_big;
  logic [BITS-1:0] one_hot;
  int              zeros;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sh_ovf_d = sh_ovf_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    b_big    = (32'(bus.i_b) >= 32'(BITS));
    one_hot  = {{(BITS-1){1'b0}}, 1'b1} << bus.i_b;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          state_d = DONE;
          out_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          case (bus.i_op)
            3'b000: begin
              out_d = bus.i_a - bus.i_b;
              ovf_d = (bus.i_a < bus.i_b);
            end
            3'b001: out_d = {{(BITS-1){1'b0}}, (bus.i_a > bus.i_b)};
            3'b010, 3'b100: begin
              if (b_big) begin
                err_d = 1'b1;
              end else if (bus.i_b == '0) begin
                out_d = bus.i_a;
              end else begin
                state_d  = SHIFT;
                work_d   = bus.i_a;
                cnt_d    = bus.i_b[CW-1:0];
                left_d   = (bus.i_op == 3'b010);
                sh_ovf_d = 1'b0;
              end
            end
            3'b011: begin
              if (b_big) err_d = 1'b1;
              else       out_d = bus.i_a ^ one_hot;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (left_q) begin
          sh_ovf_d = sh_ovf_q | work_q[BITS-1];
          work_d   = work_q << 1;
        end else begin
          sh_ovf_d = sh_ovf_q | work_q[0];
          work_d   = work_q >> 1;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          out_d   = work_d;
          ovf_d   = sh_ovf_d;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flags are registered alongside the result so they need no decode after the flop.
    zeros = 0;
    for (int i = 0; i < BITS; i++) begin
      if (!out_d[i]) zeros = zeros + 1;
    end
    even_d   = (state_d == DONE) && !zeros[0];
    single_d = (state_d == DONE) && (zeros == 1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sh_ovf_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      even_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sh_ovf_q <= sh_ovf_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      even_q   <= even_d;
      single_q <= single_d;
    end
  end

`ifdef ALU_STICKY_ERR_EN
  logic sticky_q, sticky_d;

  // Set has priority over a clear arriving on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (i_err_clr) sticky_d = 1'b0;
    if ((state_q != DONE) && (state_d == DONE) && err_d) sticky_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign o_err_sticky = sticky_q;
`endif

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_out    = out_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_ERR    = err_q;
  assign bus.o_even   = even_q;
  assign bus.o_single = single_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (BITS=8); k below counts rising edges after the accept edge
// until o_valid is seen, so a result registered at accept gives k=0 and a shift by b gives k=b.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_seq_if #(.BITS(8)) bus ();

`ifdef ALU_STICKY_ERR_EN
  logic err_clr = 1'b0;
  logic err_sticky;
`endif

  alu_seq #(.BITS(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef ALU_STICKY_ERR_EN
    ,
    .i_err_clr    (err_clr),
    .o_err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int k);
    @(negedge clk);
    bus.i_op = op; bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    k = 0;
    while (!bus.o_valid && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    if (!bus.o_valid) k = -1;
  endtask

  task automatic take();
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    bus.i_a = 8'h00; bus.i_b = 8'h00; bus.i_op = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_out !== 8'h00) begin failures++; $display("FAIL rst_out got=%h exp=00", bus.o_out); end
    checks++; if ({bus.o_ovf, bus.o_ERR, bus.o_even, bus.o_single} !== 4'b0000) begin
      failures++; $display("FAIL rst_flags got=%b exp=0000", {bus.o_ovf, bus.o_ERR, bus.o_even, bus.o_single}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.o_ready); end
`ifdef ALU_STICKY_ERR_EN
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rst_sticky got=%b exp=0", err_sticky); end
`endif
  endtask

  task automatic test_sub();
    int k;
    send(3'b000, 8'd5, 8'd7, k);
    checks++; if (k !== 0) begin failures++; $display("FAIL sub_latency got=%0d exp=0", k); end
    checks++; if (bus.o_out !== 8'hFE) begin failures++; $display("FAIL sub_out got=%h exp=fe", bus.o_out); end
    checks++; if ({bus.o_ovf, bus.o_ERR} !== 2'b10) begin failures++; $display("FAIL sub_ovf_err got=%b exp=10", {bus.o_ovf, bus.o_ERR}); end
    checks++; if ({bus.o_single, bus.o_even} !== 2'b10) begin failures++; $display("FAIL sub_flags got=%b exp=10", {bus.o_single, bus.o_even}); end
    take();
    checks++; if ({bus.o_valid, bus.o_ready} !== 2'b01) begin failures++; $display("FAIL sub_taken got=%b exp=01", {bus.o_valid, bus.o_ready}); end
    checks++; if ({bus.o_single, bus.o_even} !== 2'b00) begin failures++; $display("FAIL sub_flags_idle got=%b exp=00", {bus.o_single, bus.o_even}); end
  endtask

  task automatic test_shift();
    int k;
    logic [2:0] op [4]  = '{3'b010, 3'b100, 3'b100, 3'b100};
    logic [7:0] a  [4]  = '{8'h81, 8'h01, 8'h0C, 8'h03};
    logic [7:0] b  [4]  = '{8'd3,  8'd0,  8'd2,  8'd1};
    logic [7:0] eo [4]  = '{8'h08, 8'h01, 8'h03, 8'h01};
    logic       ev [4]  = '{1'b1,  1'b0,  1'b0,  1'b1};
    int         lat [4] = '{3, 0, 2, 1};
    for (int i = 0; i < 4; i++) begin
      send(op[i], a[i], b[i], k);
      checks++; if (k !== lat[i]) begin failures++; $display("FAIL shift%0d_latency got=%0d exp=%0d", i, k, lat[i]); end
      checks++; if (bus.o_out !== eo[i]) begin failures++; $display("FAIL shift%0d_out got=%h exp=%h", i, bus.o_out, eo[i]); end
      checks++; if (bus.o_ovf !== ev[i]) begin failures++; $display("FAIL shift%0d_ovf got=%b exp=%b", i, bus.o_ovf, ev[i]); end
      if (i == 0) begin
        checks++; if ({bus.o_even, bus.o_single} !== 2'b00) begin
          failures++; $display("FAIL shl_flags got=%b exp=00", {bus.o_even, bus.o_single}); end
      end
      take();
    end
  endtask

  task automatic test_errors();
    int k;
    logic [2:0] op [3] = '{3'b010, 3'b011, 3'b110};
    logic [7:0] b  [3] = '{8'd8, 8'd9, 8'd0};
    for (int i = 0; i < 3; i++) begin
      send(op[i], 8'hFF, b[i], k);
      checks++; if (k !== 0) begin failures++; $display("FAIL err%0d_latency got=%0d exp=0", i, k); end
      checks++; if ({bus.o_ERR, bus.o_ovf} !== 2'b10) begin failures++; $display("FAIL err%0d_err_ovf got=%b exp=10", i, {bus.o_ERR, bus.o_ovf}); end
      checks++; if (bus.o_out !== 8'h00) begin failures++; $display("FAIL err%0d_out got=%h exp=00", i, bus.o_out); end
      checks++; if ({bus.o_even, bus.o_single} !== 2'b10) begin failures++; $display("FAIL err%0d_flags got=%b exp=10", i, {bus.o_even, bus.o_single}); end
      take();
    end
`ifdef ALU_STICKY_ERR_EN
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL sticky_set got=%b exp=1", err_sticky); end
    @(negedge clk) err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clr got=%b exp=0", err_sticky); end
`endif
  endtask

  task automatic test_chg_cmp();
    int k;
    logic [2:0] op [3] = '{3'b011, 3'b001, 3'b001};
    logic [7:0] a  [3] = '{8'h0F, 8'd3, 8'd9};
    logic [7:0] b  [3] = '{8'd7,  8'd9, 8'd3};
    logic [7:0] eo [3] = '{8'h8F, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) begin
      send(op[i], a[i], b[i], k);
      checks++; if (bus.o_out !== eo[i]) begin failures++; $display("FAIL chgcmp%0d_out got=%h exp=%h", i, bus.o_out, eo[i]); end
      checks++; if ({bus.o_ERR, bus.o_ovf} !== 2'b00) begin failures++; $display("FAIL chgcmp%0d_err_ovf got=%b exp=00", i, {bus.o_ERR, bus.o_ovf}); end
      take();
    end
  endtask

  task automatic test_backpressure();
    int k;
    send(3'b000, 8'h10, 8'h01, k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_op = 3'b011; bus.i_a = 8'(i * 37); bus.i_b = 8'(i);
      @(posedge clk);
      #1;
      checks++; if ({bus.o_valid, bus.o_ready} !== 2'b10) begin failures++; $display("FAIL bp%0d_hs got=%b exp=10", i, {bus.o_valid, bus.o_ready}); end
      checks++; if ({bus.o_out, bus.o_ovf, bus.o_even} !== {8'h0F, 1'b0, 1'b1}) begin
        failures++; $display("FAIL bp%0d_hold got=%h/%b/%b exp=0f/0/1", i, bus.o_out, bus.o_ovf, bus.o_even); end
    end
    @(negedge clk) bus.i_valid = 1'b0;
    take();
    checks++; if ({bus.o_valid, bus.o_ready} !== 2'b01) begin failures++; $display("FAIL bp_release got=%b exp=01", {bus.o_valid, bus.o_ready}); end
    send(3'b001, 8'd9, 8'd3, k);
    checks++; if ({bus.o_out, bus.o_ERR} !== {8'h01, 1'b0}) begin failures++; $display("FAIL bp_next got=%h/%b exp=01/0", bus.o_out, bus.o_ERR); end
    take();
  endtask

  task automatic test_reset_mid();
    int k;
    int seen;
    @(negedge clk);
    bus.i_op = 3'b010; bus.i_a = 8'h03; bus.i_b = 8'd6; bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if ({bus.o_out, bus.o_valid, bus.o_ovf, bus.o_ERR} !== 11'h000) begin
      failures++; $display("FAIL midrst_outputs got=%h/%b/%b/%b exp=00/0/0/0", bus.o_out, bus.o_valid, bus.o_ovf, bus.o_ERR); end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (bus.o_valid || !bus.o_ready) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_result got=%0d busy_cycles exp=0", seen); end
    send(3'b000, 8'd9, 8'd4, k);
    checks++; if ({bus.o_out, bus.o_ovf} !== {8'h05, 1'b0}) begin failures++; $display("FAIL midrst_next got=%h/%b exp=05/0", bus.o_out, bus.o_ovf); end
    checks++; if (k !== 0) begin failures++; $display("FAIL midrst_latency got=%0d exp=0", k); end
    take();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_shift();
    test_errors();
    test_chg_cmp();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
